// File: rtl/pc_sequencer.sv
// Instruction sequencer for the PC / program-memory fetch path.
// Steps each instruction through FETCH -> EXEC -> NEXT (with S_MEM for stores to data memory),
// drives the PC count enable, and supports run, single-step and halt modes.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for i_start (run) or i_step (single-step)
// S_FETCH | instruction register load, opcode latched
// S_EXEC  | one-cycle execute strobe for the decoded opcode
// S_MEM   | data-memory write request held, waiting on i_dm_ack
// S_NEXT  | PC count enable, retired-instruction count update
// S_HALT  | stopped; i_start clears PC, error and count and returns to idle
module pc_sequencer #(
  parameter logic [4:0] END_ADDR    = 5'd7,
  parameter int         TIMEOUT_CYC = 8,
  parameter int         CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_step_mode,
  input  logic             i_step,
  input  logic             i_halt_req,
  input  logic [4:0]       i_pc_addr,
  input  logic [3:0]       i_opcode,
  input  logic             i_dm_ack,
  output logic             o_pc_ce,
  output logic             o_pc_clr,
  output logic             o_ir_load,
  output logic             o_acc_ld,
  output logic             o_alu_en,
  output logic             o_rf_we,
  output logic             o_dm_req,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_err,
  output logic [CNT_W-1:0] o_instr_cnt
);

  // Opcode encoding shared with pc_progmem.
  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_LD      = 4'h1;
  localparam logic [3:0] OP_ST      = 4'h2;
  localparam logic [3:0] OP_ADD     = 4'h3;
  localparam logic [3:0] OP_XOR_BIT = 4'h4;
  localparam logic [3:0] OP_STM     = 4'h5;

  // Ack timeout is a down-counter loaded on entry to S_MEM; terminal count 0 means
  // TIMEOUT_CYC cycles have been spent waiting.
  localparam int                WAIT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_NEXT,
    S_HALT
  } state_t;

  state_t            state;
  logic [3:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              halt_pend;

  // Sequencer FSM; every output is a register set on the edge entering the state it belongs to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      op_q        <= OP_NOP;
      wait_cnt    <= '0;
      halt_pend   <= 1'b0;
      o_pc_ce     <= 1'b0;
      o_pc_clr    <= 1'b0;
      o_ir_load   <= 1'b0;
      o_acc_ld    <= 1'b0;
      o_alu_en    <= 1'b0;
      o_rf_we     <= 1'b0;
      o_dm_req    <= 1'b0;
      o_busy      <= 1'b0;
      o_halted    <= 1'b0;
      o_err       <= 1'b0;
      o_instr_cnt <= '0;
    end else begin
      o_pc_ce   <= 1'b0;
      o_pc_clr  <= 1'b0;
      o_ir_load <= 1'b0;
      o_acc_ld  <= 1'b0;
      o_alu_en  <= 1'b0;
      o_rf_we   <= 1'b0;

      // A halt request is remembered until the instruction in flight retires.
      if (i_halt_req && state != S_HALT) halt_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (i_halt_req || halt_pend) begin
            state     <= S_HALT;
            halt_pend <= 1'b0;
            o_halted  <= 1'b1;
          end else if (i_step_mode ? i_step : i_start) begin
            state     <= S_FETCH;
            o_ir_load <= 1'b1;
            o_busy    <= 1'b1;
          end
        end

        // Strobes are decoded from the opcode being latched so they appear during S_EXEC.
        S_FETCH: begin
          op_q     <= i_opcode;
          o_acc_ld <= (i_opcode == OP_LD);
          o_alu_en <= (i_opcode == OP_ADD) || (i_opcode == OP_XOR_BIT);
          o_rf_we  <= (i_opcode == OP_ST);
          state    <= S_EXEC;
        end

        S_EXEC: begin
          if (op_q == OP_STM) begin
            state    <= S_MEM;
            o_dm_req <= 1'b1;
            wait_cnt <= WAIT_LOAD;
          end else begin
            state   <= S_NEXT;
            o_pc_ce <= 1'b1;
            if (o_instr_cnt != '1) o_instr_cnt <= o_instr_cnt + 1'b1;
          end
        end

        // Ack is checked before the terminal count so an ack on the last cycle still completes.
        S_MEM: begin
          if (i_dm_ack) begin
            o_dm_req <= 1'b0;
            state    <= S_NEXT;
            o_pc_ce  <= 1'b1;
            if (o_instr_cnt != '1) o_instr_cnt <= o_instr_cnt + 1'b1;
          end else if (wait_cnt == '0) begin
            o_dm_req  <= 1'b0;
            o_err     <= 1'b1;
            o_busy    <= 1'b0;
            o_halted  <= 1'b1;
            halt_pend <= 1'b0;
            state     <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        S_NEXT: begin
          if (i_pc_addr == END_ADDR || halt_pend || i_halt_req) begin
            state     <= S_HALT;
            halt_pend <= 1'b0;
            o_busy    <= 1'b0;
            o_halted  <= 1'b1;
          end else if (i_step_mode) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else begin
            state     <= S_FETCH;
            o_ir_load <= 1'b1;
          end
        end

        S_HALT: begin
          if (i_start) begin
            state       <= S_IDLE;
            o_halted    <= 1'b0;
            o_pc_clr    <= 1'b1;
            o_err       <= 1'b0;
            o_instr_cnt <= '0;
          end
        end

        default: begin
          state    <= S_IDLE;
          o_busy   <= 1'b0;
          o_halted <= 1'b0;
          o_dm_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small program-memory/PC model and a data-memory ack model.
module tb_pc_sequencer;

  localparam logic [3:0] OP_NOP = 4'h0, OP_LD = 4'h1, OP_ST = 4'h2, OP_ADD = 4'h3,
                         OP_XOR_BIT = 4'h4, OP_STM = 4'h5;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_start = 1'b0, i_step_mode = 1'b0, i_step = 1'b0, i_halt_req = 1'b0;
  logic [4:0] i_pc_addr;
  logic [3:0] i_opcode;
  logic       i_dm_ack = 1'b0;
  logic       o_pc_ce, o_pc_clr, o_ir_load, o_acc_ld, o_alu_en, o_rf_we, o_dm_req;
  logic       o_busy, o_halted, o_err;
  logic [7:0] o_instr_cnt;

  pc_sequencer #(.END_ADDR(5'd7), .TIMEOUT_CYC(8), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_step_mode(i_step_mode),
    .i_step(i_step), .i_halt_req(i_halt_req), .i_pc_addr(i_pc_addr), .i_opcode(i_opcode),
    .i_dm_ack(i_dm_ack), .o_pc_ce(o_pc_ce), .o_pc_clr(o_pc_clr), .o_ir_load(o_ir_load),
    .o_acc_ld(o_acc_ld), .o_alu_en(o_alu_en), .o_rf_we(o_rf_we), .o_dm_req(o_dm_req),
    .o_busy(o_busy), .o_halted(o_halted), .o_err(o_err), .o_instr_cnt(o_instr_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Program memory and PC model
  logic [3:0] prog [0:31];
  logic [4:0] pc_q = 5'd0;
  logic       pc_hold = 1'b0;
  assign i_pc_addr = pc_q;
  assign i_opcode  = prog[pc_q];

  always @(posedge i_clk) begin
    if (o_pc_clr) pc_q <= 5'd0;
    else if (o_pc_ce && !pc_hold) pc_q <= pc_q + 5'd1;
  end

  // Data-memory ack model: ack once req has been seen for ack_delay cycles
  logic ack_en = 1'b1;
  int   ack_delay = 1;
  int   req_cyc = 0;
  always @(negedge i_clk) begin
    if (o_dm_req) req_cyc = req_cyc + 1;
    else req_cyc = 0;
    i_dm_ack = ack_en && o_dm_req && (req_cyc >= ack_delay);
  end

  // Strobe monitor (cumulative counts; tests compare deltas)
  int n_ir = 0, n_acc = 0, n_alu = 0, n_rf = 0, n_ce = 0, n_clr = 0, n_dm = 0, n_busy = 0;
  int seq[$];
  logic dm_prev = 1'b0;
  always @(negedge i_clk) begin
    if (o_ir_load) n_ir++;
    if (o_acc_ld) begin n_acc++; seq.push_back(1); end
    if (o_alu_en) begin n_alu++; seq.push_back(2); end
    if (o_rf_we)  begin n_rf++;  seq.push_back(3); end
    if (o_dm_req && !dm_prev) seq.push_back(4);
    if (o_dm_req) n_dm++;
    if (o_pc_ce)  n_ce++;
    if (o_pc_clr) n_clr++;
    if (o_busy)   n_busy++;
    dm_prev = o_dm_req;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge i_clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
  endtask

  int s_ir, s_acc, s_alu, s_rf, s_ce, s_clr, s_dm, s_busy, s_seq;
  task automatic snap();
    s_ir = n_ir; s_acc = n_acc; s_alu = n_alu; s_rf = n_rf; s_ce = n_ce;
    s_clr = n_clr; s_dm = n_dm; s_busy = n_busy; s_seq = seq.size();
  endtask

  int exp_seq[7];
  int n;

  initial begin
    for (int i = 0; i < 32; i++) prog[i] = OP_NOP;
    prog[0] = OP_LD;  prog[1] = OP_ST;  prog[2] = OP_LD;  prog[3] = OP_ADD;
    prog[4] = OP_ST;  prog[5] = OP_XOR_BIT; prog[6] = OP_STM; prog[7] = OP_NOP;
    exp_seq = '{1, 3, 1, 2, 3, 2, 4};

    // Reset values, checked while reset is held and again after release
    #1 i_rst_n = 1'b0;
    #2;
    chk("rst_busy", o_busy, 0);
    chk("rst_dm_req", o_dm_req, 0);
    cyc(2);
    i_rst_n = 1'b1;
    cyc(1);
    chk("rst_halted", o_halted, 0);
    chk("rst_err", o_err, 0);
    chk("rst_cnt", o_instr_cnt, 0);
    chk("rst_strobes", {o_pc_ce, o_pc_clr, o_ir_load, o_acc_ld, o_alu_en, o_rf_we}, 0);

    // Run mode through the whole program; STM acked on its first S_MEM cycle
    snap();
    pulse_start();
    n = 0;
    while (!o_halted && n < 100) begin cyc(1); n++; end
    chk("run_halted", o_halted, 1);
    chk("run_busy_cycles", n_busy - s_busy, 25);
    chk("run_cnt", o_instr_cnt, 8);
    chk("run_pc_ce", n_ce - s_ce, 8);
    chk("run_ir_load", n_ir - s_ir, 8);
    chk("run_acc", n_acc - s_acc, 2);
    chk("run_alu", n_alu - s_alu, 2);
    chk("run_rf", n_rf - s_rf, 2);
    chk("run_dm_cycles", n_dm - s_dm, 1);
    chk("run_seq_len", seq.size() - s_seq, 7);
    for (int i = 0; i < 7; i++)
      if (s_seq + i < seq.size()) chk($sformatf("run_seq%0d", i), seq[s_seq + i], exp_seq[i]);

    // Restart from halt
    snap();
    i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
    chk("restart_pc_clr", o_pc_clr, 1);
    chk("restart_halted", o_halted, 0);
    chk("restart_cnt", o_instr_cnt, 0);
    cyc(1);
    chk("restart_pc_clr_pulses", n_clr - s_clr, 1);
    chk("restart_pc", pc_q, 0);

    // Single step: one instruction each
    i_step_mode = 1'b1;
    snap();
    i_step = 1'b1;
    cyc(1);
    i_step = 1'b0;
    cyc(4);
    chk("step1_busy", o_busy, 0);
    chk("step1_halted", o_halted, 0);
    chk("step1_cnt", o_instr_cnt, 1);
    chk("step1_pc_ce", n_ce - s_ce, 1);
    chk("step1_busy_cycles", n_busy - s_busy, 3);
    chk("step1_acc", n_acc - s_acc, 1);
    snap();
    i_step = 1'b1;
    cyc(1);
    i_step = 1'b0;
    cyc(4);
    chk("step2_cnt", o_instr_cnt, 2);
    chk("step2_rf", n_rf - s_rf, 1);
    chk("step2_ir_load", n_ir - s_ir, 1);

    // Halt request during EXEC of ADD (LD at pc 2 runs first)
    i_step_mode = 1'b0;
    snap();
    pulse_start();
    n = 0;
    while (!o_alu_en && n < 20) begin cyc(1); n++; end
    chk("halt_alu_seen", o_alu_en, 1);
    i_halt_req = 1'b1;
    cyc(1);
    i_halt_req = 1'b0;
    chk("halt_pc_ce_in_next", o_pc_ce, 1);
    cyc(2);
    chk("halt_halted", o_halted, 1);
    chk("halt_alu", n_alu - s_alu, 1);
    chk("halt_pc_ce", n_ce - s_ce, 2);
    chk("halt_cnt", o_instr_cnt, 4);

    // STM with no ack: timeout
    pulse_start();
    prog[0] = OP_STM;
    ack_en = 1'b0;
    snap();
    pulse_start();
    n = 0;
    while (!o_halted && n < 40) begin cyc(1); n++; end
    chk("tmo_halted", o_halted, 1);
    chk("tmo_err", o_err, 1);
    chk("tmo_dm_cycles", n_dm - s_dm, 8);
    chk("tmo_pc_ce", n_ce - s_ce, 0);
    chk("tmo_dm_req_low", o_dm_req, 0);

    // Reset in the middle of S_MEM
    pulse_start();
    chk("tmo_err_cleared", o_err, 0);
    pulse_start();
    n = 0;
    while (!o_dm_req && n < 20) begin cyc(1); n++; end
    chk("arst_in_mem", o_dm_req, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_dm_req", o_dm_req, 0);
    chk("arst_busy", o_busy, 0);
    cyc(1);
    i_rst_n = 1'b1;
    snap();
    cyc(2);
    chk("arst_idle_busy", o_busy, 0);
    chk("arst_idle_halted", o_halted, 0);
    chk("arst_idle_no_fetch", n_ir - s_ir, 0);
    prog[0] = OP_LD;
    ack_en = 1'b1;

    // Start and halt together in S_IDLE: halt wins
    snap();
    i_start = 1'b1;
    i_halt_req = 1'b1;
    cyc(1);
    i_start = 1'b0;
    i_halt_req = 1'b0;
    chk("both_halted", o_halted, 1);
    chk("both_busy", o_busy, 0);
    cyc(1);
    chk("both_no_fetch", n_ir - s_ir, 0);

    // Counter saturation with PC held away from END_ADDR
    pulse_start();
    pc_hold = 1'b1;
    pulse_start();
    n = 0;
    while (o_instr_cnt != 8'hFF && n < 1000) begin cyc(1); n++; end
    chk("sat_reach_ff", o_instr_cnt, 8'hFF);
    snap();
    n = 0;
    while ((n_ce - s_ce) < 2 && n < 20) begin cyc(1); n++; end
    chk("sat_more_retired", n_ce - s_ce, 2);
    chk("sat_hold_ff", o_instr_cnt, 8'hFF);
    i_halt_req = 1'b1;
    cyc(1);
    i_halt_req = 1'b0;
    cyc(5);
    chk("sat_halted", o_halted, 1);
    chk("sat_final_ff", o_instr_cnt, 8'hFF);
    pc_hold = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
